branch_resolve_ctrl: RTL and testbench

Branch resolution controller between the IF-stage YAGS predictor and the EX-stage branch/jump decision logic. It records every prediction made in IF in an in-order queue and compares each prediction against the actual EX outcome. On a mispredict it sequences a multi-cycle pipeline flush and a PC redirect. It also schedules predictor-update writes through a buffered valid/ready handshake.

---
 rtl/branch_resolve_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: matches IF predictions against EX outcomes,
// sequences flush/redirect on mispredict, buffers predictor updates.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int UPD_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid_IF,
  input  logic        pred_taken_IF,
  input  logic [31:0] pred_target_IF,
  input  logic        res_valid_EX,
  input  logic        res_is_branch_EX,
  input  logic        res_taken_EX,
  input  logic [31:0] res_pc_EX,
  input  logic [31:0] res_target_EX,
  input  logic        upd_ready,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_mispredict,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        stall_IF,
  output logic        stall_EX,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  output logic        err_underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int UW  = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int UCW = UW + 1;
  localparam int FW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;

  logic          pq_taken  [DEPTH];
  logic [31:0]   pq_target [DEPTH];
  logic [AW-1:0] pq_rd;
  logic [AW-1:0] pq_wr;
  logic [CW-1:0] pq_cnt;

  logic [31:0]    uq_pc     [UPD_DEPTH];
  logic           uq_taken  [UPD_DEPTH];
  logic [31:0]    uq_target [UPD_DEPTH];
  logic           uq_mis    [UPD_DEPTH];
  logic [UW-1:0]  uq_rd;
  logic [UW-1:0]  uq_wr;
  logic [UCW-1:0] uq_cnt;

  logic        accept;
  logic        pq_empty;
  logic        head_taken;
  logic [31:0] head_target;
  logic        mispredict;
  logic [31:0] fix_pc;
  logic        push;
  logic        pop;
  logic        enq;
  logic        deq;

  function automatic logic [UW-1:0] uq_next(input logic [UW-1:0] p);
    return (p == UW'(UPD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stalls depend only on registered occupancy and FSM state
  assign stall_IF = (pq_cnt == CW'(DEPTH)) || (state == FLUSH);
  assign stall_EX = (uq_cnt == UCW'(UPD_DEPTH));

  assign accept   = res_valid_EX && !stall_EX && (state == IDLE);
  assign pq_empty = (pq_cnt == '0);

  // An empty queue means the fetch stream was never predicted: treat as not-taken
  assign head_taken  = !pq_empty && pq_taken[pq_rd];
  assign head_target = pq_target[pq_rd];

  assign mispredict = accept &&
                      ((head_taken != res_taken_EX) ||
                       (head_taken && res_taken_EX &&
                        (head_target != res_target_EX)));

  assign fix_pc = res_taken_EX ? res_target_EX : res_pc_EX + 32'd4;

  assign push = pred_valid_IF && !stall_IF;
  assign pop  = accept && !pq_empty;
  assign enq  = accept && res_is_branch_EX;
  assign deq  = upd_valid && upd_ready;

  assign upd_valid      = (uq_cnt != '0);
  assign upd_pc         = uq_pc[uq_rd];
  assign upd_target     = uq_target[uq_rd];
  assign upd_taken      = uq_taken[uq_rd];
  assign upd_mispredict = uq_mis[uq_rd];

  // Prediction queue: wiped on mispredict, same-cycle push is wrong-path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pq_rd  <= '0;
      pq_wr  <= '0;
      pq_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pq_taken[i]  <= 1'b0;
        pq_target[i] <= '0;
      end
    end else if (mispredict) begin
      pq_rd  <= '0;
      pq_wr  <= '0;
      pq_cnt <= '0;
    end else begin
      if (push) begin
        pq_taken[pq_wr]  <= pred_taken_IF;
        pq_target[pq_wr] <= pred_target_IF;
        pq_wr            <= pq_wr + 1'b1;
      end
      if (pop) begin
        pq_rd <= pq_rd + 1'b1;
      end
      pq_cnt <= pq_cnt + CW'(push) - CW'(pop);
    end
  end

  // Update buffer: resolved branches survive flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uq_rd  <= '0;
      uq_wr  <= '0;
      uq_cnt <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) begin
        uq_pc[i]     <= '0;
        uq_taken[i]  <= 1'b0;
        uq_target[i] <= '0;
        uq_mis[i]    <= 1'b0;
      end
    end else begin
      if (enq) begin
        uq_pc[uq_wr]     <= res_pc_EX;
        uq_taken[uq_wr]  <= res_taken_EX;
        uq_target[uq_wr] <= res_target_EX;
        uq_mis[uq_wr]    <= mispredict;
        uq_wr            <= uq_next(uq_wr);
      end
      if (deq) begin
        uq_rd <= uq_next(uq_rd);
      end
      uq_cnt <= uq_cnt + UCW'(enq) - UCW'(deq);
    end
  end

  // Flush sequencer with registered flush/redirect outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mispredict) begin
            state          <= FLUSH;
            flush_cnt      <= FW'(FLUSH_CYCLES - 1);
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= fix_pc;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Statistics and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      err_underflow    <= 1'b0;
    end else begin
      if (enq) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (accept && pq_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed plan plus random traffic
// checked against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int UD    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic        res_valid_EX;
  logic        res_is_branch_EX;
  logic        res_taken_EX;
  logic [31:0] res_pc_EX;
  logic [31:0] res_target_EX;
  logic        upd_ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_IF;
  logic        stall_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        err_underflow;

  branch_resolve_ctrl #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FC),
    .UPD_DEPTH(UD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pred_valid_IF(pred_valid_IF),
    .pred_taken_IF(pred_taken_IF),
    .pred_target_IF(pred_target_IF),
    .res_valid_EX(res_valid_EX),
    .res_is_branch_EX(res_is_branch_EX),
    .res_taken_EX(res_taken_EX),
    .res_pc_EX(res_pc_EX),
    .res_target_EX(res_target_EX),
    .upd_ready(upd_ready),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_target(upd_target),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall_IF(stall_IF),
    .stall_EX(stall_EX),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic [31:0] tg;
  } pred_t;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
    logic        mis;
  } upd_t;

  pred_t       pq[$];
  upd_t        uq[$];
  int          flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;
  logic        m_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    uq.delete();
    flush_left = 0;
    m_rv  = 1'b0;
    m_rpc = '0;
    m_bc  = '0;
    m_mc  = '0;
    m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("flush", 32'(flush), 32'(flush_left > 0));
    chk("redir_v", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redir_pc", redirect_pc, m_rpc);
    chk("stall_IF", 32'(stall_IF),
        32'((pq.size() == DEPTH) || (flush_left > 0)));
    chk("stall_EX", 32'(stall_EX), 32'(uq.size() == UD));
    chk("upd_valid", 32'(upd_valid), 32'(uq.size() > 0));
    if (uq.size() > 0) begin
      chk("upd_pc", upd_pc, uq[0].pc);
      chk("upd_tgt", upd_target, uq[0].tg);
      chk("upd_tk", 32'(upd_taken), 32'(uq[0].tk));
      chk("upd_mis", 32'(upd_mispredict), 32'(uq[0].mis));
    end
    chk("br_cnt", branch_count, m_bc);
    chk("mp_cnt", mispredict_count, m_mc);
    chk("err_uf", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic step(input logic pv, input logic pt,
                      input logic [31:0] ptg, input logic rv,
                      input logic rb, input logic rt,
                      input logic [31:0] rpc, input logic [31:0] rtg,
                      input logic ur);
    bit    s_if;
    bit    s_ex;
    bit    acc;
    bit    psh;
    bit    mis;
    pred_t p;
    pred_t n;
    upd_t  u;
    s_if = (pq.size() == DEPTH) || (flush_left > 0);
    s_ex = (uq.size() == UD);
    acc  = rv && !s_ex && (flush_left == 0);
    psh  = pv && !s_if;
    p.tk = 1'b0;
    p.tg = '0;
    n.tk = pt;
    n.tg = ptg;
    m_rv = 1'b0;
    if (flush_left > 0) flush_left--;
    if (ur && uq.size() > 0) void'(uq.pop_front());
    if (acc) begin
      if (pq.size() == 0) m_err = 1'b1;
      else p = pq[0];
      mis = (p.tk != rt) || (p.tk && rt && (p.tg != rtg));
      if (rb) begin
        m_bc++;
        u.pc  = rpc;
        u.tk  = rt;
        u.tg  = rtg;
        u.mis = mis;
        uq.push_back(u);
      end
      if (mis) begin
        m_mc++;
        pq.delete();
        flush_left = FC;
        m_rv  = 1'b1;
        m_rpc = rt ? rtg : rpc + 32'd4;
      end else begin
        if (pq.size() > 0) void'(pq.pop_front());
        if (psh) pq.push_back(n);
      end
    end else if (psh) begin
      pq.push_back(n);
    end
  endtask

  task automatic cyc(input logic pv, input logic pt,
                     input logic [31:0] ptg, input logic rv,
                     input logic rb, input logic rt,
                     input logic [31:0] rpc, input logic [31:0] rtg,
                     input logic ur);
    @(negedge clk);
    check_all();
    pred_valid_IF    = pv;
    pred_taken_IF    = pt;
    pred_target_IF   = ptg;
    res_valid_EX     = rv;
    res_is_branch_EX = rb;
    res_taken_EX     = rt;
    res_pc_EX        = rpc;
    res_target_EX    = rtg;
    upd_ready        = ur;
    step(pv, pt, ptg, rv, rb, rt, rpc, rtg, ur);
  endtask

  task automatic idle(input logic ur);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, ur);
  endtask

  task automatic pred(input logic tk, input logic [31:0] tg);
    cyc(1'b1, tk, tg, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic res(input logic rb, input logic rt,
                     input logic [31:0] pc, input logic [31:0] tg,
                     input logic ur);
    cyc(1'b0, 1'b0, '0, 1'b1, rb, rt, pc, tg, ur);
  endtask

  task automatic drive_idle();
    pred_valid_IF    = 1'b0;
    pred_taken_IF    = 1'b0;
    pred_target_IF   = '0;
    res_valid_EX     = 1'b0;
    res_is_branch_EX = 1'b0;
    res_taken_EX     = 1'b0;
    res_pc_EX        = '0;
    res_target_EX    = '0;
    upd_ready        = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    #3;
    check_all();
    chk("rst_rpc", redirect_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // three correct taken predictions
    repeat (3) pred(1'b1, 32'h100);
    for (int i = 0; i < 3; i++)
      res(1'b1, 1'b1, 32'h10 + 32'(i * 4), 32'h100, 1'b1);
    repeat (2) idle(1'b1);
    chk("p1_bc", branch_count, 32'd3);
    chk("p1_mc", mispredict_count, 32'd0);
    chk("p1_upd", 32'(upd_valid), 32'd0);

    // not-taken predicted, actually taken
    pred(1'b0, 32'h0);
    res(1'b1, 1'b1, 32'h40, 32'h80, 1'b1);
    idle(1'b1);
    chk("p2_rv1", 32'(redirect_valid), 32'd1);
    chk("p2_rpc", redirect_pc, 32'h80);
    chk("p2_fl1", 32'(flush), 32'd1);
    idle(1'b1);
    chk("p2_rv2", 32'(redirect_valid), 32'd0);
    chk("p2_fl2", 32'(flush), 32'd1);
    idle(1'b1);
    chk("p2_fl3", 32'(flush), 32'd0);
    chk("p2_mc", mispredict_count, 32'd1);

    // wrong target, then taken-vs-not-taken
    pred(1'b1, 32'h200);
    res(1'b1, 1'b1, 32'h50, 32'h204, 1'b1);
    idle(1'b1);
    chk("p3_rpc1", redirect_pc, 32'h204);
    repeat (2) idle(1'b1);
    pred(1'b1, 32'h300);
    res(1'b1, 1'b0, 32'h3C, 32'h0, 1'b1);
    idle(1'b1);
    chk("p3_rpc2", redirect_pc, 32'h40);
    chk("p3_mc", mispredict_count, 32'd3);
    repeat (2) idle(1'b1);

    // full prediction queue
    repeat (4) pred(1'b1, 32'h10);
    pred(1'b1, 32'h20);
    chk("p4_full", 32'(stall_IF), 32'd1);
    res(1'b0, 1'b1, 32'h60, 32'h10, 1'b1);
    idle(1'b1);
    chk("p4_free", 32'(stall_IF), 32'd0);
    for (int i = 0; i < 3; i++)
      res(1'b0, 1'b1, 32'h64 + 32'(i * 4), 32'h10, 1'b1);
    idle(1'b1);
    chk("p4_mc", mispredict_count, 32'd3);

    // update back-pressure
    repeat (3) pred(1'b0, 32'h0);
    res(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    res(1'b1, 1'b0, 32'h1004, 32'h0, 1'b0);
    res(1'b1, 1'b0, 32'h1008, 32'h0, 1'b0);
    chk("p5_sex", 32'(stall_EX), 32'd1);
    chk("p5_pc0", upd_pc, 32'h1000);
    res(1'b1, 1'b0, 32'h1008, 32'h0, 1'b0);
    chk("p5_hold", upd_pc, 32'h1000);
    chk("p5_bc", branch_count, 32'd8);
    idle(1'b1);
    chk("p5_out0", upd_pc, 32'h1000);
    idle(1'b1);
    chk("p5_out1", upd_pc, 32'h1004);
    idle(1'b1);
    chk("p5_empty", 32'(upd_valid), 32'd0);
    res(1'b1, 1'b0, 32'h1008, 32'h0, 1'b1);
    repeat (2) idle(1'b1);

    // underflow, then reset in the middle of a flush
    res(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1);
    idle(1'b1);
    chk("p6_err", 32'(err_underflow), 32'd1);
    chk("p6_nofl", 32'(flush), 32'd0);
    repeat (2) idle(1'b1);
    chk("p6_stky", 32'(err_underflow), 32'd1);
    pred(1'b0, 32'h0);
    res(1'b1, 1'b1, 32'h2100, 32'h2200, 1'b1);
    idle(1'b1);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    chk("p6_rfl", 32'(flush), 32'd0);
    chk("p6_rrv", 32'(redirect_valid), 32'd0);
    chk("p6_rbc", branch_count, 32'd0);
    chk("p6_rmc", mispredict_count, 32'd0);
    chk("p6_rerr", 32'(err_underflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        pv;
      logic        pt;
      logic [31:0] ptg;
      logic        rv;
      logic        rb;
      logic        rt;
      logic [31:0] rpc;
      logic [31:0] rtg;
      logic        ur;
      pv  = ($urandom_range(0, 2) != 0);
      pt  = $urandom_range(0, 1) == 1;
      ptg = 32'($urandom_range(0, 3)) << 4;
      rv  = ($urandom_range(0, 4) < 2);
      rb  = ($urandom_range(0, 3) != 0);
      rt  = rb ? ($urandom_range(0, 1) == 1) : 1'b1;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      rtg = 32'($urandom_range(0, 3)) << 4;
      ur  = ($urandom_range(0, 9) < 7);
      cyc(pv, pt, ptg, rv, rb, rt, rpc, rtg, ur);
    end
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
